board_io_bridge: RTL
====================

Name: board_io_bridge

Overview:
Parametrised board-side I/O bridge between raw FPGA board pins and the tt_um_sid core pin interface. It replaces direct pin wiring with:
- synchronised, glitch-filtered SPI inputs;
- debounced buttons with edge pulses;
- a stretched core reset;
- a registered PDM output;
- a switch-selectable LED debug mux with heartbeat.
It runs entirely in the core clock domain and sits between the board top level and tt_um_sid.

Parameters:
N_BTN, 4, number of pushbuttons (>=1); btn[0] is the core reset button
SYNC_STAGES, 2, flip-flop stages on every raw input (>=2)
DEBOUNCE_CYCLES, 500000, clocks a button must be stable before it is accepted (10 ms at 50 MHz; >=2)
RST_HOLD, 16, clocks core_rst_n stays low after all reset sources clear (>=1)
HB_LOG2, 25, heartbeat counter width; LED toggles every 2^(HB_LOG2-1) clocks
PDM_BIT, 1, index of core_uo_out driven to pdm_out

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
btn_raw  in  N_BTN  raw pushbuttons, active high
sw_raw  in  4  raw slide switches
spi_clk_raw  in  1  raw SPI clock pin
spi_cs_n_raw  in  1  raw SPI chip select, active low
spi_mosi_raw  in  1  raw SPI data pin
core_uo_out  in  8  core dedicated outputs
ui_in  out  8  to core: {5'b0, mosi, sclk, cs_n}
core_rst_n  out  1  to core reset
core_ena  out  1  to core ena
btn_level  out  N_BTN  debounced button levels
btn_pulse  out  N_BTN  one-cycle pulse on debounced rising edge
pdm_out  out  1  registered audio bit
led  out  4  debug LEDs

Behaviour:
- rst_n low clears all state asynchronously. Reset values:
  - synchroniser/filter chains: btn 0, sw 0, sclk 0, cs_n 1, mosi 0;
  - ui_in = 8'h01;
  - core_rst_n = 0;
  - core_ena = 0;
  - btn_level = 0, btn_pulse = 0;
  - pdm_out = 0;
  - led = 0;
  - all counters = 0.
- Synchronisers: each raw input passes through SYNC_STAGES flops; sync output follows raw with SYNC_STAGES clocks latency.
- SPI glitch filter, per signal:
  - 3-bit history shift register of the sync output feeds a filter register;
  - filter register loads the new value only when all 3 history bits agree, otherwise holds;
  - a clean edge reaches ui_in exactly SYNC_STAGES+3 clocks after the raw edge;
  - pulses of <=2 clocks at sync output never reach ui_in.
- ui_in[7:3] is constant 0.
- Debounce, per button: counter cnt, stable level lvl.
  - sync==lvl: cnt<=0.
  - sync!=lvl and cnt==DEBOUNCE_CYCLES-1: lvl<=sync, cnt<=0.
  - otherwise: cnt<=cnt+1.
  - Net effect: a level held for DEBOUNCE_CYCLES consecutive clocks is accepted; any bounce back restarts the count.
  - btn_level=lvl; btn_pulse[i]=1 for exactly the one clock after lvl[i] rises; no pulse on fall.
- Core reset:
  - rst_n low forces core_rst_n=0 asynchronously;
  - btn_level[0]=1 forces core_rst_n=0 on the next clock and reloads the hold counter;
  - once rst_n high and btn_level[0]=0, a hold counter counts RST_HOLD clocks, then core_rst_n=1;
  - any reassertion mid-count restarts the full hold.
- core_ena = sync sw[0]; changes SYNC_STAGES clocks after sw_raw[0]; not debounced.
- pdm_out <= core_uo_out[PDM_BIT] every clock; 1 clock latency.
- Heartbeat: free-running HB_LOG2-bit counter, wraps to 0, runs during core reset.
- LED mux, selected by sync sw[2:1], 1 clock registered:
  - 00: core_uo_out[3:0];
  - 01: core_uo_out[7:4];
  - 10: btn_level zero-extended or truncated to 4 bits;
  - 11: {3'b0, heartbeat MSB}.
- sw[3] is reserved and ignored.
- Simultaneous events: button bounce during an active count restarts only that button's counter; the other buttons are independent.

Test Plan:
- Reset: hold rst_n low 5 clocks, raw cs_n=0 -> ui_in=8'h01, core_rst_n=0, led=0. Release -> core_rst_n rises exactly RST_HOLD clocks after rst_n and btn[0] clear.
- SPI latency and glitch: spi_clk_raw rises and stays high -> ui_in[1] rises at clock SYNC_STAGES+3. A 2-clock high pulse on spi_mosi_raw -> ui_in[2] stays 0.
- Debounce (DEBOUNCE_CYCLES=8): btn_raw[1] toggles every 3 clocks for 30 clocks, then holds 1 -> btn_level[1] rises exactly 8 clocks after the sync output settles, a single btn_pulse[1], no pulse on release.
- Reset button: btn_level[0]=1 for 1 clock, then rst_n low mid-hold -> core_rst_n low immediately. After full release, core_rst_n=1 only after a full RST_HOLD.
- LED mux: core_uo_out=8'hA5, sw=4'b0000/0010/0100/0110 -> led=4'h5 / 4'hA / btn_level / heartbeat. With HB_LOG2=4, led[0] toggles every 8 clocks.
- PDM/ena: toggle core_uo_out[1] each clock -> pdm_out mirrors it 1 clock later. sw_raw[0]=1 -> core_ena=1 after SYNC_STAGES clocks.

Source files
------------

// File: rtl/board_io_bridge.sv
// board_io_bridge
// Board-side conditioning between raw FPGA pins and the tt_um_sid core pins.
// Everything runs in the core clock domain.
//
// Ports
//   clk, rst_n       core clock, asynchronous active-low reset
//   btn_raw          raw pushbuttons (active high); btn[0] is the core reset button
//   sw_raw           raw slide switches: [0] core enable, [2:1] LED select, [3] unused
//   spi_*_raw        raw SPI pins (clock, active-low chip select, data)
//   core_uo_out      core dedicated outputs
//   ui_in            to core: {5'b0, mosi, sclk, cs_n}, glitch filtered
//   core_rst_n       stretched core reset
//   core_ena         synchronised sw[0]
//   btn_level        debounced button levels
//   btn_pulse        one-clock pulse when a debounced level rises
//   pdm_out          registered core_uo_out[PDM_BIT]
//   led              switch-selected debug view
module board_io_bridge #(
    parameter int N_BTN           = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int RST_HOLD        = 16,
    parameter int HB_LOG2         = 25,
    parameter int PDM_BIT         = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] btn_raw,
    input  logic [3:0]       sw_raw,
    input  logic             spi_clk_raw,
    input  logic             spi_cs_n_raw,
    input  logic             spi_mosi_raw,
    input  logic [7:0]       core_uo_out,
    output logic [7:0]       ui_in,
    output logic             core_rst_n,
    output logic             core_ena,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_pulse,
    output logic             pdm_out,
    output logic [3:0]       led
);

    // All raw inputs share one synchroniser vector:
    // [N_BTN-1:0] buttons, then 4 switches, then cs_n, sclk, mosi (ui_in[2:0] order).
    localparam int W      = N_BTN + 7;
    localparam int SW_LSB = N_BTN;
    localparam int CS_BIT = N_BTN + 4;
    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES);
    localparam int HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;

    // cs_n idles high, every other synchronised input idles low
    localparam logic [W-1:0]       SYNC_RST  = {{(W-1){1'b0}}, 1'b1} << CS_BIT;
    localparam logic [DB_W-1:0]    DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DB_W-1:0]    DB_ONE    = DB_W'(1'b1);
    localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(RST_HOLD - 1);
    localparam logic [HOLD_W-1:0]  HOLD_ONE  = HOLD_W'(1'b1);
    localparam logic [HB_LOG2-1:0] HB_ONE    = HB_LOG2'(1'b1);

    logic [W-1:0]       raw_s;
    logic [W-1:0]       sync_d [SYNC_STAGES];
    logic [W-1:0]       sync_q [SYNC_STAGES];
    logic [W-1:0]       sync_s;
    logic [N_BTN-1:0]   btn_sync_s;
    logic [3:0]         sw_sync_s;
    logic [2:0]         spi_sync_s;

    logic [2:0]         hist0_d, hist0_q, hist1_d, hist1_q;
    logic [2:0]         filt_d, filt_q;

    logic [DB_W-1:0]    db_cnt_d [N_BTN];
    logic [DB_W-1:0]    db_cnt_q [N_BTN];
    logic [N_BTN-1:0]   lvl_d, lvl_q, pulse_d, pulse_q;

    logic [HOLD_W-1:0]  hold_cnt_d, hold_cnt_q;
    logic               core_rst_n_d, core_rst_n_q;

    logic               pdm_d, pdm_q;
    logic [HB_LOG2-1:0] hb_d, hb_q;
    logic [3:0]         led_d, led_q;
    logic [N_BTN+3:0]   lvl_pad_s;
    logic               unused_s;

    assign raw_s      = {spi_mosi_raw, spi_clk_raw, spi_cs_n_raw, sw_raw, btn_raw};
    assign sync_s     = sync_q[SYNC_STAGES-1];
    assign btn_sync_s = sync_s[N_BTN-1:0];
    assign sw_sync_s  = sync_s[SW_LSB+3:SW_LSB];
    assign spi_sync_s = sync_s[CS_BIT+2:CS_BIT];
    assign lvl_pad_s  = {4'b0000, lvl_q};
    // sw[3] is reserved; button levels above bit 3 never reach the LEDs
    assign unused_s   = ^{sw_sync_s[3], lvl_pad_s[N_BTN+3:4]};

    // Synchroniser chain next-state: shift raw pins one stage per clock
    always_comb begin
        sync_d[0] = raw_s;
        for (int k = 1; k < SYNC_STAGES; k++) begin
            sync_d[k] = sync_q[k-1];
        end
    end

    // Synchroniser chain registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= SYNC_RST;
            end
        end else begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_d[k];
            end
        end
    end

    // SPI glitch filter next-state. The 3-sample window is the current sync
    // output plus its two previous samples; the filter takes a new value only
    // when all three agree, so a clean edge lands 3 clocks after the sync edge
    // and pulses of 2 clocks or less are swallowed.
    always_comb begin
        hist0_d = spi_sync_s;
        hist1_d = hist0_q;
        filt_d  = (filt_q | (spi_sync_s & hist0_q & hist1_q))
                & (spi_sync_s | hist0_q | hist1_q);
    end

    // SPI glitch filter registers (cs_n lane idles high)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist0_q <= 3'b001;
            hist1_q <= 3'b001;
            filt_q  <= 3'b001;
        end else begin
            hist0_q <= hist0_d;
            hist1_q <= hist1_d;
            filt_q  <= filt_d;
        end
    end

    // Debounce next-state: count clocks the sync level differs from the
    // accepted level, accept it after DEBOUNCE_CYCLES, restart on any bounce
    always_comb begin
        for (int i = 0; i < N_BTN; i++) begin
            db_cnt_d[i] = db_cnt_q[i];
            lvl_d[i]    = lvl_q[i];
            if (btn_sync_s[i] == lvl_q[i]) begin
                db_cnt_d[i] = '0;
            end else if (db_cnt_q[i] == DB_LAST) begin
                lvl_d[i]    = btn_sync_s[i];
                db_cnt_d[i] = '0;
            end else begin
                db_cnt_d[i] = db_cnt_q[i] + DB_ONE;
            end
        end
        // pulse is high during the first clock the new level is visible
        pulse_d = lvl_d & ~lvl_q;
    end

    // Debounce registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_BTN; i++) begin
                db_cnt_q[i] <= '0;
            end
            lvl_q   <= '0;
            pulse_q <= '0;
        end else begin
            for (int i = 0; i < N_BTN; i++) begin
                db_cnt_q[i] <= db_cnt_d[i];
            end
            lvl_q   <= lvl_d;
            pulse_q <= pulse_d;
        end
    end

    // Core reset stretcher next-state: button 0 holds the core in reset and
    // reloads the counter; release takes RST_HOLD clocks of quiet
    always_comb begin
        hold_cnt_d   = hold_cnt_q;
        core_rst_n_d = core_rst_n_q;
        if (lvl_q[0]) begin
            hold_cnt_d   = '0;
            core_rst_n_d = 1'b0;
        end else if (!core_rst_n_q) begin
            if (hold_cnt_q == HOLD_LAST) begin
                core_rst_n_d = 1'b1;
            end else begin
                hold_cnt_d = hold_cnt_q + HOLD_ONE;
            end
        end else begin
            hold_cnt_d   = hold_cnt_q;
            core_rst_n_d = 1'b1;
        end
    end

    // PDM, heartbeat and LED mux next-state
    always_comb begin
        pdm_d = core_uo_out[PDM_BIT];
        hb_d  = hb_q + HB_ONE;
        case (sw_sync_s[2:1])
            2'b00:   led_d = core_uo_out[3:0];
            2'b01:   led_d = core_uo_out[7:4];
            2'b10:   led_d = lvl_pad_s[3:0];
            2'b11:   led_d = {3'b000, hb_q[HB_LOG2-1]};
            default: led_d = 4'b0000;
        endcase
    end

    // Core reset, PDM, heartbeat and LED registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt_q   <= '0;
            core_rst_n_q <= 1'b0;
            pdm_q        <= 1'b0;
            hb_q         <= '0;
            led_q        <= 4'b0000;
        end else begin
            hold_cnt_q   <= hold_cnt_d;
            core_rst_n_q <= core_rst_n_d;
            pdm_q        <= pdm_d;
            hb_q         <= hb_d;
            led_q        <= led_d;
        end
    end

    assign ui_in      = {5'b00000, filt_q};
    assign core_rst_n = core_rst_n_q;
    assign core_ena   = sync_s[SW_LSB];
    assign btn_level  = lvl_q;
    assign btn_pulse  = pulse_q;
    assign pdm_out    = pdm_q;
    assign led        = led_q;

endmodule
